output_spike_recorder: RTL

OUTPUT_SPIKE_RECORDER -- requirements
Module: output_spike_recorder

---
 rtl/output_spike_recorder.sv | 112 +++++++++++
 1 files changed

// File: rtl/output_spike_recorder.sv
// Output spike recorder: stamps output-layer spikes with a 6-bit timestep
// counter and queues them in a first-word-fall-through FIFO for readout.
// Optional per-neuron saturating spike counters are built only when the
// macro SPIKE_COUNTERS_EN is defined.
module output_spike_recorder #(
  parameter int DEPTH = 8
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       delay_clk,
  input  logic [1:0] output_spikes,
  input  logic       clear,
  input  logic       rd_en,
  output logic [7:0] event_data,
  output logic       event_valid,
  output logic [4:0] fifo_count,
  output logic       overflow,
  output logic [7:0] spike_count_0,
  output logic [7:0] spike_count_1
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          delay_clk_q;
  logic [5:0]    timestamp;
  logic          tick;
  logic          fire;
  logic          push_req;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Tick detection and FIFO push/pop arbitration.
  always_comb begin
    tick     = delay_clk & ~delay_clk_q;
    fire     = tick & enable;
    push_req = fire & (output_spikes != 2'b00);
    empty    = (count == '0);
    full     = (count == 5'(DEPTH));
    pop      = rd_en & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  // Delayed copy of the timestep clock for rising-edge detection.
  always_ff @(posedge system_clock) begin
    if (!reset) delay_clk_q <= 1'b0;
    else        delay_clk_q <= delay_clk;
  end

  // Timestep counter, advancing once per enabled tick and wrapping at 63.
  always_ff @(posedge system_clock) begin
    if (!reset || clear) timestamp <= '0;
    else if (fire)       timestamp <= timestamp + 6'd1;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge system_clock) begin
    if (!reset || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // FIFO storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge system_clock) begin
    if (push && reset && !clear) mem[wr_ptr] <= {output_spikes, timestamp};
  end

  // First-word-fall-through head presentation.
  always_comb begin
    event_valid = ~empty;
    event_data  = empty ? 8'h00 : mem[rd_ptr];
    fifo_count  = count;
  end

`ifdef SPIKE_COUNTERS_EN
  // Per-neuron spike totals, saturating at 255, independent of FIFO state.
  always_ff @(posedge system_clock) begin
    if (!reset || clear) begin
      spike_count_0 <= '0;
      spike_count_1 <= '0;
    end else if (fire) begin
      if (output_spikes[0] && spike_count_0 != 8'hFF) spike_count_0 <= spike_count_0 + 8'd1;
      if (output_spikes[1] && spike_count_1 != 8'hFF) spike_count_1 <= spike_count_1 + 8'd1;
    end
  end
`else
  assign spike_count_0 = '0;
  assign spike_count_1 = '0;
`endif

endmodule
